// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Returns {remainder, quotient} with a ready handshake held while start stays high.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               sgn_q, sgn_d;
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               abort;

    // The partial remainder is always below 2^(WIDTH-1) before a shift, so its MSB can be dropped.
    always_comb begin
        shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, dvs_q};
        quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -quo_q : quo_q;
        rem_fix = (sgn_q && neg1_q) ? -rem_q : rem_q;
        abort   = annul || !start;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        sgn_d    = sgn_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    sgn_d   = signed_div;
                    neg1_d  = opdata1[WIDTH-1];
                    neg2_d  = opdata2[WIDTH-1];
                    dvd_d   = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                    dvs_d   = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = (opdata2 == '0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    result_d = '0;
                    state_d  = DONE;
                end
            end
            ON: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_STEP) begin
                    result_d = {rem_fix, quo_fix};
                    state_d  = DONE;
                end else begin
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == DONE);
        busy_d  = (state_d == ON) || (state_d == DIVZERO);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            sgn_q    <= sgn_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: scoreboard of expected {remainder, quotient}
// values pushed at request time and popped when ready is seen.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_div(signed_div),
        .annul     (annul),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .result    (result),
        .ready     (ready),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        if (b == 32'd0) return 64'd0;
        ua = (sd && a[31]) ? (32'd0 - a) : a;
        ub = (sd && b[31]) ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (sd && (a[31] ^ b[31])) q = 32'd0 - q;
        if (sd && a[31])           r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;
        tick(); tick(); tick();
        n_tests++;
        if ({result, ready, busy} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got result=%h ready=%b busy=%b want all 0", result, ready, busy);
        end
        resetn = 1'b1;
        tick();
        n_tests++;
        if ({result, ready, busy} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_release: got result=%h ready=%b busy=%b want all 0", result, ready, busy);
        end
        $display("[TB] reset checked");
    endtask

    // Cycle 0 is the cycle in which start is first driven high in IDLE.
    task automatic test_div(input string name, input logic sd, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat);
        logic [63:0] e;
        int          cyc;
        opdata1 = a; opdata2 = b; signed_div = sd; start = 1'b1;
        exp_q.push_back(model(sd, a, b));
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_c1: got %b want 1", name, busy);
        end
        // Later operand changes must not disturb the accepted operation.
        opdata1 = ~a; opdata2 = 32'd0; signed_div = ~sd;
        cyc = 1;
        while (!ready && cyc < 100) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got cycle %0d want %0d", name, cyc, exp_lat);
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue want entry", name);
        end else begin
            e = exp_q.pop_front();
            if (result !== e) begin
                n_fail++;
                $display("FAIL %s result: got %h want %h", name, result, e);
            end
        end
        $display("[TB] %s sd=%0d %h / %h -> %h ready@%0d", name, sd, a, b, result, cyc);
        start = 1'b0;
        tick();
        n_tests++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: got ready=%b busy=%b want 0 0", name, ready, busy);
        end
    endtask

    task automatic test_busy_timing();
        logic [63:0] e;
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        exp_q.push_back(model(1'b0, 32'd100, 32'd7));
        for (int c = 1; c <= 34; c++) begin
            tick();
            n_tests++;
            if (busy !== (c <= 33) || ready !== (c == 34)) begin
                n_fail++;
                $display("FAIL timing_c%0d: got busy=%b ready=%b want busy=%b ready=%b",
                         c, busy, ready, (c <= 33), (c == 34));
            end
        end
        e = exp_q.pop_front();
        n_tests++;
        if (result !== e || e !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL timing_result: got %h want %h", result, {32'd2, 32'd14});
        end
        $display("[TB] timing 100/7 -> %h", result);
        start = 1'b0;
        tick();
    endtask

    task automatic test_annul();
        logic [63:0] e;
        int          cyc;
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_tests++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL annul_noready_c%0d: got %b want 0", c, ready);
            end
        end
        annul = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_idle: got busy=%b ready=%b want 0 0", busy, ready);
        end
        annul = 1'b0; start = 1'b0;
        tick();
        opdata1 = 32'd20; opdata2 = 32'd3; start = 1'b1;
        exp_q.push_back(model(1'b0, 32'd20, 32'd3));
        cyc = 12;
        while (!ready && cyc < 140) begin
            tick();
            cyc++;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (cyc !== 46 || result !== e) begin
            n_fail++;
            $display("FAIL annul_next: got cycle %0d result %h want 46 %h", cyc, result, e);
        end
        $display("[TB] after annul 20/3 -> %h ready@%0d", result, cyc);
        // annul in DONE with start still high
        annul = 1'b1;
        tick();
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_done: got ready=%b want 0", ready);
        end
        // start and annul together in IDLE must not be accepted
        tick();
        n_tests++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_annul_idle: got busy=%b ready=%b want 0 0", busy, ready);
        end
        annul = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_hold_done();
        logic [63:0] e;
        logic [63:0] held;
        int          cyc;
        opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
        exp_q.push_back(model(1'b0, 32'd50, 32'd5));
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!ready && cyc < 100);
        e = exp_q.pop_front();
        n_tests++;
        if (result !== e) begin
            n_fail++;
            $display("FAIL hold_result: got %h want %h", result, e);
        end
        held = e;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (ready !== 1'b1 || result !== held) begin
                n_fail++;
                $display("FAIL hold_c%0d: got ready=%b result=%h want 1 %h", c, ready, result, held);
            end
        end
        start = 1'b0;
        tick();
        n_tests++;
        if (ready !== 1'b0 || result !== held) begin
            n_fail++;
            $display("FAIL hold_drop: got ready=%b result=%h want 0 %h", ready, result, held);
        end
        $display("[TB] hold 50/5 -> %h", held);
    endtask

    task automatic test_reset_mid();
        opdata1 = 32'd12345; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        resetn = 1'b0;
        #1;
        n_tests++;
        if (result !== 64'd0 || busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got result=%h busy=%b ready=%b want 0 0 0", result, busy, ready);
        end
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        $display("[TB] async reset during ON");
    endtask

    initial begin
        test_reset();
        test_busy_timing();
        test_div("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2, 34);
        test_div("u_m7_2",  1'b0, 32'hFFFF_FFF9, 32'd2, 34);
        test_div("div0_u",  1'b0, 32'd123, 32'd0, 2);
        test_div("div0_s",  1'b1, 32'h8000_0000, 32'd0, 2);
        test_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34);
        test_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34);
        test_div("u_big_dvs", 1'b0, 32'hFFFF_FFFF, 32'hC000_0000, 34);
        test_div("s_neg_neg", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34);
        for (int i = 0; i < 4; i++) begin
            test_div("rand", 1'(i), $urandom, $urandom_range(1, 32'hFFFF), 34);
        end
        test_annul();
        test_hold_done();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle division sequencer serving the execute-stage ALU for DIV/DIVU. Accepts a start request with two 32-bit operands. Runs a radix-2 restoring divide, one quotient bit per cycle. Returns `{remainder, quotient}` as a 64-bit HI/LO value with a ready handshake. The ALU holds the pipeline stalled while `start` is high and `ready` is low, then writes `result` into HI/LO.

## Interface
- `WIDTH`, 32, operand width; the iteration counter is `$clog2(WIDTH)+1` bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: divide request, held high by the pipeline until `ready` is seen.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `annul` in 1: cancel the current operation (pipeline flush or exception).
- `opdata1` in WIDTH: dividend.
- `opdata2` in WIDTH: divisor.
- `result` out 2*WIDTH: `{remainder, quotient}` (HI = remainder, LO = quotient).
- `ready` out 1: result valid; held high while in DONE.
- `busy` out 1: high in ON and DIVZERO.

## Operation
- States: IDLE, DIVZERO, ON, DONE. Reset values: state IDLE, `result` 0, `ready` 0, `busy` 0, counter 0.
- **IDLE:**
  - If `start` is high and `annul` is low, latch `signed_div`, both operand signs, and both operands.
    - Signed mode latches absolute values.
    - Unsigned mode latches raw values.
  - If `opdata2` is 0, go to DIVZERO; otherwise go to ON with counter 0 and partial remainder 0.
  - Operand changes after acceptance are ignored.
- **ON, counter < WIDTH:** one restoring step per cycle.
  - `trial = {rem[WIDTH-2:0], dividend_msb} - divisor`, with the dividend shifted left each step.
  - If `trial` is non-negative, set `rem = trial` and shift in quotient bit 1.
  - Otherwise `rem` keeps the shifted value and quotient bit 0 is shifted in.
  - The counter increments each step.
- **ON, counter == WIDTH:** apply sign correction, then load `result` and go to DONE.
  - Signed only: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
- **DIVZERO:** on the next edge load `result = 0` and go to DONE.
- **DONE:** `ready` = 1 and `result` is stable. When `start` is low, return to IDLE; `ready` is 0 from the following cycle.
- **Abort:** `annul` high, or `start` low, while in ON or DIVZERO returns to IDLE on the next edge.
  - `ready` stays 0 and `result` is unchanged.
- `annul` in DONE also returns to IDLE.
- `start` and `annul` high together in IDLE: the request is not accepted.
- Signed `0x80000000 / 0xFFFFFFFF` produces quotient `0x80000000`, remainder 0, with no trap; this is the natural result of the algorithm.
- `result` retains its last value in IDLE; consumers qualify it with `ready`.
- `resetn` low at any point forces all reset values immediately, independent of `clk`.

## Timing
- Cycle 0: `start` sampled high in IDLE; the edge ending cycle 0 enters ON (or DIVZERO).
- Normal divide: WIDTH step edges follow, plus one finalize edge. `ready` is first high in cycle WIDTH+2 (cycle 34 for WIDTH=32).
- Divide by zero: `ready` is first high in cycle 2.
- `ready` drops in the cycle after `start` is first seen low in DONE. A new request can be accepted in the cycle after that (IDLE).
- No back-to-back acceptance without passing through IDLE for at least one cycle.
- `busy` is registered with the state; it is high exactly in the cycles the state is ON or DIVZERO.

## Test plan
- Unsigned `100 / 7`, `start` held: `ready` rises in cycle 34, `result = {32'd2, 32'd14}`; `busy` is high cycles 1–33.
- Signed `-7 / 2` (`0xFFFFFFF9`, 2): quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`. Unsigned with the same operands: quotient `0x7FFFFFFC`, remainder 1.
- Divisor 0 (any dividend, both modes): `ready` in cycle 2, `result = 0`.
- Signed `0x80000000 / 0xFFFFFFFF` gives `{0, 0x80000000}`. Unsigned `0xFFFFFFFF / 1` gives `{0, 0xFFFFFFFF}`.
- `annul` pulsed in cycle 10 gives IDLE in cycle 11 with `ready` never asserted. A new `20 / 3` accepted in cycle 12 gives `{2, 6}` with `ready` in cycle 46.
- Hold `start` 5 cycles in DONE: `ready` and `result` stay stable. Drop `start`: `ready` = 0 the next cycle. `resetn` low mid-ON: immediate IDLE with `result = 0` and `busy = 0`.
